masked_rand_source: RTL and testbench

- Producer side of the fresh-randomness interface that the masked gadgets consume, such as the HPC2 multiplier's per-pair random bits.
- Seeded 32-bit Galois LFSR, advanced NUM_RAND steps per delivered word.
- Valid/ready handshake towards the gadget; seed-load handshake towards the system.
- Enforces warm-up after every seed and a reseed limit.

---
 rtl/masked_rand_source.sv | 185 ++++++++++++++++++
 tb/tb_masked_rand_source.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_rand_source.sv
// masked_rand_source
//   Producer of fresh randomness for masked gadgets, for example the per-pair
//   random bits of an HPC2 multiplier. A seeded 32-bit Galois LFSR supplies
//   the bits. It advances NUM_RAND single steps for every word it delivers.
//   After each seed the LFSR runs through a warm-up period, and output stops
//   once RESEED_PERIOD words have been delivered from the same seed.
//
// Parameters:
//   NUM_SHARES     share count of the consumer; NUM_RAND = NUM_SHARES*(NUM_SHARES-1)/2
//   WARMUP_CYCLES  advances after a seed before output is enabled (0 allowed)
//   RESEED_PERIOD  words per seed before output stops (0 = unlimited)
//
// Ports:
//   in_clock, in_reset         clock, asynchronous active-high reset
//   in_seed, in_seed_valid     seed offer from the system
//   out_seed_ready             a seed can be accepted this cycle
//   out_r, out_r_valid         random word and its valid flag (registered)
//   in_r_ready                 consumer takes out_r this cycle
//   out_reseed_req             reseed limit reached, output stopped
//   out_health_err             (only with MASKED_RAND_SOURCE_HEALTH_EN) sticky
//                              all-zero LFSR detector
//
// Optional feature macro: MASKED_RAND_SOURCE_HEALTH_EN

module masked_rand_source #(
  parameter int NUM_SHARES    = 2,
  parameter int WARMUP_CYCLES = 8,
  parameter int RESEED_PERIOD = 1024,
  localparam int NUM_RAND     = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
  input  logic                in_clock,
  input  logic                in_reset,
  input  logic [31:0]         in_seed,
  input  logic                in_seed_valid,
  output logic                out_seed_ready,
  output logic [NUM_RAND-1:0] out_r,
  output logic                out_r_valid,
  input  logic                in_r_ready,
`ifdef MASKED_RAND_SOURCE_HEALTH_EN
  output logic                out_health_err,
`endif
  output logic                out_reseed_req
);

  localparam logic [31:0] TAPS        = 32'hA3000000;
  localparam logic [31:0] WARM_LAST   = 32'(WARMUP_CYCLES - 1);
  localparam logic [31:0] RESEED_P    = 32'(RESEED_PERIOD);
  localparam logic [31:0] RESEED_LAST = 32'(RESEED_PERIOD - 1);

  // The word width has to fit inside the 32-bit LFSR. It also has to be at
  // least one bit, so a single-share consumer is rejected as well.
  if (NUM_RAND > 32 || NUM_RAND < 1) begin : g_bad_num_rand
    $error("masked_rand_source: NUM_RAND must be in 1..32");
  end

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN,
    ST_STALE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] warm_cnt_q, warm_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] seed_fixed;
  logic        health_active;
  logic        seed_accept;
  logic        take;

  // One advance is NUM_RAND chained Galois steps. They are unrolled into a
  // single combinational cone so that a full word is produced every cycle.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < NUM_RAND; i++) begin
      v = {1'b0, v[31:1]} ^ (v[0] ? TAPS : 32'h0);
    end
    return v;
  endfunction

`ifdef MASKED_RAND_SOURCE_HEALTH_EN
  logic health_err_q, health_err_d;
  assign health_active  = health_err_q;
  assign out_health_err = health_err_q;
`else
  assign health_active  = 1'b0;
`endif

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  // While reset is held, seed_ready is forced low so that no seed can be
  // taken during reset. A raised health error reopens the seed path even in
  // warm-up, because reseeding is the only recovery apart from reset.
  assign seed_fixed     = (in_seed == 32'h0) ? 32'h1 : in_seed;
  assign out_seed_ready = !in_reset && ((state_q != ST_WARMUP) || health_active);
  assign out_r_valid    = (state_q == ST_RUN) && !health_active;
  assign out_reseed_req = (state_q == ST_STALE);
  assign out_r          = lfsr_q[NUM_RAND-1:0];
  assign seed_accept    = in_seed_valid && out_seed_ready;
  assign take           = out_r_valid && in_r_ready;

  // The next-state logic handles warm-up counting and word delivery with
  // reseed limiting. An accepted seed is applied last, so it overrides any
  // advance in the same cycle. The word delivered in that cycle still counts
  // as taken, but the word counter restarts anyway.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    word_cnt_d = word_cnt_q;
`ifdef MASKED_RAND_SOURCE_HEALTH_EN
    health_err_d = health_err_q;
`endif

    case (state_q)
      ST_WARMUP: begin
        lfsr_d     = lfsr_advance(lfsr_q);
        warm_cnt_d = warm_cnt_q + 32'd1;
        if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (take) begin
          lfsr_d = lfsr_advance(lfsr_q);
          if (RESEED_PERIOD != 0) begin
            if (word_cnt_q < RESEED_P) begin
              word_cnt_d = word_cnt_q + 32'd1;
            end
            if (word_cnt_q == RESEED_LAST) begin
              state_d = ST_STALE;
            end
          end
        end
      end
      default: begin
      end
    endcase

`ifdef MASKED_RAND_SOURCE_HEALTH_EN
    if (((state_q == ST_WARMUP) || (state_q == ST_RUN)) && (lfsr_q == 32'h0)) begin
      health_err_d = 1'b1;
    end
`endif

    if (seed_accept) begin
      lfsr_d     = seed_fixed;
      warm_cnt_d = 32'h0;
      word_cnt_d = 32'h0;
      state_d    = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
`ifdef MASKED_RAND_SOURCE_HEALTH_EN
      health_err_d = 1'b0;
`endif
    end
  end

  // State register. Reset is asynchronous, so the outputs fall to their
  // reset values as soon as in_reset rises, without waiting for a clock edge.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q    <= ST_UNSEEDED;
      lfsr_q     <= 32'h0;
      warm_cnt_q <= 32'h0;
      word_cnt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef MASKED_RAND_SOURCE_HEALTH_EN
  // The health flag is sticky. Only reset or a fresh seed clears it.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      health_err_q <= 1'b0;
    end else begin
      health_err_q <= health_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_masked_rand_source.sv
// Testbench for masked_rand_source. It uses two instances:
//   dut_a: NUM_SHARES=2 (1-bit words), WARMUP_CYCLES=0, RESEED_PERIOD=4
//   dut_b: NUM_SHARES=8 (28-bit words), WARMUP_CYCLES=8, RESEED_PERIOD=0
// Expected words come from an independent LFSR model and are queued when
// seeds are driven. They are popped when the DUT completes a handshake.

module tb_masked_rand_source;

  logic        clk;
  logic        rst;

  logic [31:0] a_seed;
  logic        a_seed_valid;
  logic        a_seed_ready;
  logic [0:0]  a_r;
  logic        a_r_valid;
  logic        a_r_ready;
  logic        a_reseed_req;

  logic [31:0] b_seed;
  logic        b_seed_valid;
  logic        b_seed_ready;
  logic [27:0] b_r;
  logic        b_r_valid;
  logic        b_r_ready;
  logic        b_reseed_req;

  int          checks_total;
  int          checks_passed;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  typedef struct packed {
    logic        sv;
    logic [31:0] seed;
    logic        rr;
    logic        exp_valid;
    logic        exp_sr;
    logic        exp_rq;
  } vec_t;

  vec_t a_vecs[18];

  masked_rand_source #(
    .NUM_SHARES(2), .WARMUP_CYCLES(0), .RESEED_PERIOD(4)
  ) dut_a (
    .in_clock(clk), .in_reset(rst),
    .in_seed(a_seed), .in_seed_valid(a_seed_valid), .out_seed_ready(a_seed_ready),
    .out_r(a_r), .out_r_valid(a_r_valid), .in_r_ready(a_r_ready),
    .out_reseed_req(a_reseed_req)
  );

  masked_rand_source #(
    .NUM_SHARES(8), .WARMUP_CYCLES(8), .RESEED_PERIOD(0)
  ) dut_b (
    .in_clock(clk), .in_reset(rst),
    .in_seed(b_seed), .in_seed_valid(b_seed_valid), .out_seed_ready(b_seed_ready),
    .out_r(b_r), .out_r_valid(b_r_valid), .in_r_ready(b_r_ready),
    .out_reseed_req(b_reseed_req)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that stops a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference LFSR. Each step shifts right and applies the taps when the bit
  // shifted out was 1.
  function automatic logic [31:0] model_adv(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      if (v[0]) v = (v >> 1) ^ 32'hA3000000;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drives one dut_a vector at the falling edge and checks the registered
  // outputs 1 unit later. The handshake resolves on the next rising edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] m;
    @(negedge clk);
    a_seed_valid = v.sv;
    a_seed       = v.seed;
    a_r_ready    = v.rr;
    #1;
    checkOutput($sformatf("a[%0d] r_valid", idx), 32'(a_r_valid), 32'(v.exp_valid));
    checkOutput($sformatf("a[%0d] seed_ready", idx), 32'(a_seed_ready), 32'(v.exp_sr));
    checkOutput($sformatf("a[%0d] reseed_req", idx), 32'(a_reseed_req), 32'(v.exp_rq));
    if (v.exp_valid) begin
      if (qa.size() == 0) begin
        checkOutput($sformatf("a[%0d] scoreboard empty", idx), 32'(qa.size()), 32'd1);
      end else begin
        checkOutput($sformatf("a[%0d] out_r", idx), 32'(a_r), qa[0]);
        if (v.rr) void'(qa.pop_front());
      end
    end
    if (v.sv && v.exp_sr) begin
      qa.delete();
      m = model_seed(v.seed);
      for (int k = 0; k < 4; k++) begin
        qa.push_back(m & 32'h1);
        m = model_adv(m, 1);
      end
    end
  endtask

  task automatic stepB(input logic sv, input logic [31:0] seed, input logic rr);
    @(negedge clk);
    b_seed_valid = sv;
    b_seed       = seed;
    b_r_ready    = rr;
    #1;
  endtask

  initial begin
    logic [31:0] m;
    int          cyc;
    bit          seen;

    checks_total  = 0;
    checks_passed = 0;
    rst           = 1'b1;
    a_seed = 32'h0; a_seed_valid = 1'b0; a_r_ready = 1'b0;
    b_seed = 32'h0; b_seed_valid = 1'b0; b_r_ready = 1'b0;

    // sv, seed, rr | exp_valid, exp_seed_ready, exp_reseed_req
    a_vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_vecs[2]  = '{1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0};
    a_vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    a_vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    a_vecs[9]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    a_vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    a_vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[12] = '{1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Outputs while reset is held.
    #1;
    checkOutput("reset a seed_ready", 32'(a_seed_ready), 32'd0);
    checkOutput("reset b seed_ready", 32'(b_seed_ready), 32'd0);
    checkOutput("reset a r_valid", 32'(a_r_valid), 32'd0);
    checkOutput("reset b out_r", 32'(b_r), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unseeded idle: no valid, seed ready, zero word.
    for (int i = 0; i < 3; i++) begin
      stepB(1'b0, 32'h0, 1'b1);
      checkOutput("idle b r_valid", 32'(b_r_valid), 32'd0);
      checkOutput("idle b seed_ready", 32'(b_seed_ready), 32'd1);
      checkOutput("idle b out_r", 32'(b_r), 32'd0);
    end

    $display("[TB] dut_a vector table");
    for (int i = 0; i < 18; i++) applyStimulus(i, a_vecs[i]);

    $display("[TB] dut_b warm-up and streaming");
    stepB(1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("b seed accept ready", 32'(b_seed_ready), 32'd1);
    m = model_adv(32'hDEADBEEF, 8 * 28);
    for (int k = 0; k < 16; k++) begin
      qb.push_back(m & 32'h0FFFFFFF);
      m = model_adv(m, 28);
    end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      stepB(1'b0, 32'h0, 1'b0);
      cyc++;
      if (b_r_valid) seen = 1'b1;
      else checkOutput($sformatf("b warmup seed_ready c%0d", cyc), 32'(b_seed_ready), 32'd0);
    end
    checkOutput("b warmup latency", 32'(cyc), 32'd9);
    checkOutput("b first word", 32'(b_r), qb[0]);

    // Continuous handshakes, then a pause where the word must hold.
    for (int k = 0; k < 6; k++) begin
      stepB(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("b stream valid %0d", k), 32'(b_r_valid), 32'd1);
      checkOutput($sformatf("b stream word %0d", k), 32'(b_r), qb.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      stepB(1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("b hold word %0d", k), 32'(b_r), qb[0]);
    end
    for (int k = 0; k < 6; k++) begin
      stepB(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("b more word %0d", k), 32'(b_r), qb.pop_front());
      checkOutput($sformatf("b no reseed %0d", k), 32'(b_reseed_req), 32'd0);
    end

    $display("[TB] asynchronous reset mid-run");
    stepB(1'b0, 32'h0, 1'b0);
    checkOutput("b valid before reset", 32'(b_r_valid), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async rst b r_valid", 32'(b_r_valid), 32'd0);
    checkOutput("async rst b seed_ready", 32'(b_seed_ready), 32'd0);
    checkOutput("async rst b out_r", 32'(b_r), 32'd0);
    checkOutput("async rst b reseed_req", 32'(b_reseed_req), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stepB(1'b0, 32'h0, 1'b1);
      checkOutput("post rst b r_valid", 32'(b_r_valid), 32'd0);
      checkOutput("post rst b seed_ready", 32'(b_seed_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
